// File: rtl/rv32i_single_cycle_core_pkg.sv
// rtl/rv32i_single_cycle_core_pkg.sv - shared opcodes, funct3 codes, enums and immediate helper
package rv32i_single_cycle_core_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_SR = 3'b101;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_B    = 2'b01,
    MW_H    = 2'b10,
    MW_W    = 2'b11
  } mem_write_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_e t);
    case (t)
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   return {instr[31:12], 12'h000};
      IMM_J:   return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return {{20{instr[31]}}, instr[31:20]};
    endcase
  endfunction

  // alt selects sub/sra; callers only raise it where the encoding allows
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_regfile.sv
// rtl/rv32_regfile.sv - 32x32 register file, x0 reads zero, async active-low clear
module rv32_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        rd_we_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (rd_we_i && (rd_addr_i != 5'd0)) begin
      regs_q[rd_addr_i] <= rd_data_i;
    end
  end

  assign rs1_data_o = (rs1_addr_i == 5'd0) ? '0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? '0 : regs_q[rs2_addr_i];

endmodule

// File: rtl/rv32i_single_cycle_core.sv
// rtl/rv32i_single_cycle_core.sv - single-cycle RV32I core: fetch, decode, execute, retire per clock
module rv32i_single_cycle_core
  import rv32i_single_cycle_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic [31:0] ReadData,
  output logic [1:0]  MemWrite,
  output logic [31:0] PC,
  output logic [31:0] ALUResult,
  output logic [31:0] WriteData
);

  logic [31:0] pc_q, pc_d;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  alu_op_e     alu_op;
  imm_type_e   imm_type;
  mem_write_e  mem_write;
  logic        alu_src_pc, alu_src_imm, reg_we;
  logic        is_load, is_branch, is_jal, is_jalr;

  logic [31:0] imm, rs1_data, rs2_data, alu_a, alu_b, alu_out, alu_result;
  logic [31:0] pc_plus4, pc_imm, load_data, wb_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        branch_taken;

  assign opcode = Instr[6:0];
  assign rd     = Instr[11:7];
  assign funct3 = Instr[14:12];
  assign rs1    = Instr[19:15];
  assign rs2    = Instr[24:20];

  always_comb begin
    alu_op      = ALU_ADD;
    imm_type    = IMM_I;
    mem_write   = MW_NONE;
    alu_src_pc  = 1'b0;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    is_load     = 1'b0;
    is_branch   = 1'b0;
    is_jal      = 1'b0;
    is_jalr     = 1'b0;
    case (opcode)
      OP_REG: begin
        reg_we = 1'b1;
        alu_op = alu_op_from_f3(funct3, Instr[30]);
      end
      OP_IMM: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        alu_op      = alu_op_from_f3(funct3, (funct3 == F3_SR) && Instr[30]);
      end
      OP_LOAD: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        is_load     = 1'b1;
      end
      OP_STORE: begin
        alu_src_imm = 1'b1;
        imm_type    = IMM_S;
        case (funct3)
          F3_SB:   mem_write = MW_B;
          F3_SH:   mem_write = MW_H;
          F3_SW:   mem_write = MW_W;
          default: mem_write = MW_NONE;
        endcase
      end
      OP_BRANCH: begin
        alu_op    = ALU_SUB;
        imm_type  = IMM_B;
        is_branch = 1'b1;
      end
      OP_JAL: begin
        reg_we      = 1'b1;
        alu_src_pc  = 1'b1;
        alu_src_imm = 1'b1;
        imm_type    = IMM_J;
        is_jal      = 1'b1;
      end
      OP_JALR: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        is_jalr     = 1'b1;
      end
      OP_LUI: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        imm_type    = IMM_U;
        alu_op      = ALU_PASSB;
      end
      OP_AUIPC: begin
        reg_we      = 1'b1;
        alu_src_pc  = 1'b1;
        alu_src_imm = 1'b1;
        imm_type    = IMM_U;
      end
      default: ;
    endcase
  end

  assign imm = gen_imm(Instr, imm_type);

  rv32_regfile u_regfile (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .rs1_addr_i (rs1),
    .rs2_addr_i (rs2),
    .rd_addr_i  (rd),
    .rd_we_i    (reg_we),
    .rd_data_i  (wb_data),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data)
  );

  assign alu_a = alu_src_pc  ? pc_q : rs1_data;
  assign alu_b = alu_src_imm ? imm  : rs2_data;

  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALU_ADD:   alu_out = alu_a + alu_b;
      ALU_SUB:   alu_out = alu_a - alu_b;
      ALU_SLL:   alu_out = alu_a << alu_b[4:0];
      ALU_SLT:   alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  alu_out = {31'd0, alu_a < alu_b};
      ALU_XOR:   alu_out = alu_a ^ alu_b;
      ALU_SRL:   alu_out = alu_a >> alu_b[4:0];
      ALU_SRA:   alu_out = $signed(alu_a) >>> alu_b[4:0];
      ALU_OR:    alu_out = alu_a | alu_b;
      ALU_AND:   alu_out = alu_a & alu_b;
      ALU_PASSB: alu_out = alu_b;
      default:   alu_out = '0;
    endcase
  end

  // jalr targets are halfword-aligned, and the aligned target is what leaves the core
  assign alu_result = is_jalr ? {alu_out[31:1], 1'b0} : alu_out;

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      F3_BEQ:  branch_taken = (rs1_data == rs2_data);
      F3_BNE:  branch_taken = (rs1_data != rs2_data);
      F3_BLT:  branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: branch_taken = (rs1_data <  rs2_data);
      F3_BGEU: branch_taken = (rs1_data >= rs2_data);
      default: branch_taken = 1'b0;
    endcase
  end

  assign load_byte = ReadData[{alu_result[1:0], 3'b000} +: 8];
  assign load_half = alu_result[1] ? ReadData[31:16] : ReadData[15:0];

  always_comb begin
    load_data = ReadData;
    case (funct3)
      F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      F3_LH:   load_data = {{16{load_half[15]}}, load_half};
      F3_LW:   load_data = ReadData;
      F3_LBU:  load_data = {24'd0, load_byte};
      F3_LHU:  load_data = {16'd0, load_half};
      default: load_data = ReadData;
    endcase
  end

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_imm   = pc_q + imm;

  always_comb begin
    if (is_load)                wb_data = load_data;
    else if (is_jal || is_jalr) wb_data = pc_plus4;
    else                        wb_data = alu_out;
  end

  always_comb begin
    if (is_jalr)                                pc_d = alu_result;
    else if (is_jal || (is_branch && branch_taken)) pc_d = pc_imm;
    else                                        pc_d = pc_plus4;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // the fetch under reset may decode as a store; keep memory quiet until released
  assign MemWrite  = RESET ? mem_write : MW_NONE;
  assign PC        = pc_q;
  assign ALUResult = alu_result;
  assign WriteData = rs2_data;

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// tb/tb_rv32i_single_cycle_core.sv - directed and random instruction checks against an ISA-level model
module tb_rv32i_single_cycle_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, rdata;
  logic [1:0]  mem_write;
  logic [31:0] pc, alu_result, write_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_x [32];
  logic [31:0] m_pc;
  logic [31:0] last_pc, last_alu, last_wd;
  logic [1:0]  last_mw;

  typedef struct {
    logic [31:0] alu;
    logic [1:0]  mw;
    logic [31:0] wd;
    bit          chk_alu;
    bit          store;
    logic [31:0] npc;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] wv;
  } exp_t;

  always #5 clk = ~clk;

  rv32i_single_cycle_core #(.RESET_PC(32'h0)) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .Instr     (instr),
    .ReadData  (rdata),
    .MemWrite  (mem_write),
    .PC        (pc),
    .ALUResult (alu_result),
    .WriteData (write_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] sw_x(input logic [4:0] rs2);
    return enc_s(12'h000, rs2, 5'd0, 3'd2);
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input bit alt,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        if (alt) r = $signed(a) >>> b[4:0];
        else     r = a >> b[4:0];
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic exp_t ref_exec(input logic [31:0] ins, input logic [31:0] rdw);
    exp_t e;
    logic [31:0] a, b, i_imm, s_imm, b_imm, u_imm, j_imm, addr, t;
    logic [2:0]  f3;
    logic [7:0]  by;
    logic [15:0] hw;
    bit tk;
    f3    = ins[14:12];
    a     = m_x[ins[19:15]];
    b     = m_x[ins[24:20]];
    i_imm = {{20{ins[31]}}, ins[31:20]};
    s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    u_imm = {ins[31:12], 12'h000};
    j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    e.alu = '0; e.mw = 2'd0; e.wd = b; e.chk_alu = 1; e.store = 0;
    e.npc = m_pc + 32'd4; e.we = 0; e.rd = ins[11:7]; e.wv = '0;
    case (ins[6:0])
      7'h33: begin e.we = 1; e.wv = alu_ref(f3, ins[30], a, b); e.alu = e.wv; end
      7'h13: begin e.we = 1; e.wv = alu_ref(f3, (f3 == 3'd5) && ins[30], a, i_imm); e.alu = e.wv; end
      7'h03: begin
        addr  = a + i_imm;
        e.alu = addr;
        e.we  = 1;
        by    = 8'(rdw >> {addr[1:0], 3'b000});
        hw    = addr[1] ? rdw[31:16] : rdw[15:0];
        case (f3)
          3'd0:    e.wv = {{24{by[7]}}, by};
          3'd1:    e.wv = {{16{hw[15]}}, hw};
          3'd2:    e.wv = rdw;
          3'd4:    e.wv = {24'd0, by};
          default: e.wv = {16'd0, hw};
        endcase
      end
      7'h23: begin
        e.alu   = a + s_imm;
        e.store = 1;
        e.mw    = (f3 == 3'd0) ? 2'd1 : (f3 == 3'd1) ? 2'd2 : 2'd3;
      end
      7'h63: begin
        e.alu = a - b;
        case (f3)
          3'd0:    tk = (a == b);
          3'd1:    tk = (a != b);
          3'd4:    tk = ($signed(a) <  $signed(b));
          3'd5:    tk = ($signed(a) >= $signed(b));
          3'd6:    tk = (a < b);
          default: tk = (a >= b);
        endcase
        if (tk) e.npc = m_pc + b_imm;
      end
      7'h6f: begin t = m_pc + j_imm; e.alu = t; e.npc = t; e.we = 1; e.wv = m_pc + 32'd4; end
      7'h67: begin t = (a + i_imm) & ~32'h1; e.alu = t; e.npc = t; e.we = 1; e.wv = m_pc + 32'd4; end
      7'h37: begin e.we = 1; e.wv = u_imm; e.alu = u_imm; end
      7'h17: begin e.we = 1; e.wv = m_pc + u_imm; e.alu = e.wv; end
      default: e.chk_alu = 0;
    endcase
    if (e.rd == 5'd0) e.we = 0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int k;
    r = $urandom;
    k = $urandom_range(0, 10);
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    f3 = r[14:12];
    case (k)
      0, 1: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[30]) ? 7'h20 : 7'h00;
        return {f7, r[24:7], 7'h33};
      end
      2, 3: begin
        f7 = r[31:25];
        if (f3 == 3'd1) f7 = 7'h00;
        else if (f3 == 3'd5) f7 = r[30] ? 7'h20 : 7'h00;
        return {f7, r[24:7], 7'h13};
      end
      4: begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
        return {r[31:15], f3, r[11:7], 7'h03};
      end
      5: begin
        f3 = 3'($urandom_range(0, 2));
        return {r[31:15], f3, r[11:7], 7'h23};
      end
      6: begin
        f3 = 3'($urandom_range(0, 5));
        if (f3 >= 3'd2) f3 = f3 + 3'd2;
        return {r[31:15], f3, r[11:7], 7'h63};
      end
      7: return {r[31:7], 7'h6f};
      8: return {r[31:15], 3'd0, r[11:7], 7'h67};
      9: return r[0] ? {r[31:7], 7'h37} : {r[31:7], 7'h17};
      default: return r[0] ? 32'h0000_0000 : {r[31:7], 7'h0b};
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
  endtask

  // drive one instruction, compare mid-cycle, then retire it in the model
  task automatic step(input logic [31:0] ins, input logic [31:0] rdw);
    exp_t e;
    instr = ins;
    rdata = rdw;
    e = ref_exec(ins, rdw);
    @(negedge clk);
    last_pc  = pc;
    last_alu = alu_result;
    last_wd  = write_data;
    last_mw  = mem_write;
    check_eq($sformatf("pc[%h]", ins), pc, m_pc);
    check_eq($sformatf("memwrite[%h]", ins), {30'd0, mem_write}, {30'd0, e.mw});
    if (e.chk_alu) check_eq($sformatf("alu_result[%h]", ins), alu_result, e.alu);
    if (e.store)   check_eq($sformatf("write_data[%h]", ins), write_data, e.wd);
    @(posedge clk);
    #1;
    m_pc = e.npc;
    if (e.we) m_x[e.rd] = e.wv;
  endtask

  initial begin
    rst_n = 1'b0;
    instr = 32'h0;
    rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_pc", pc, 32'h0);
    check_eq("reset_memwrite", {30'd0, mem_write}, 32'd0);
    instr = sw_x(5'd5);
    #1;
    check_eq("reset_memwrite_store", {30'd0, mem_write}, 32'd0);
    instr = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    repeat (3) step(32'h0, 32'h0);
    check_eq("nop_pc", pc, 32'h0000_000C);

    step(enc_i(12'd11, 5'd0, 3'd0, 5'd6, 7'h13), 32'h0);
    step(enc_i(12'd19, 5'd6, 3'd2, 5'd7, 7'h13), 32'h0);
    step(enc_i(12'd15, 5'd6, 3'd3, 5'd8, 7'h13), 32'h0);
    step(enc_r(7'h20, 5'd7, 5'd6, 3'd0, 5'd3), 32'h0);
    step(enc_r(7'h00, 5'd6, 5'd6, 3'd0, 5'd0), 32'h0);
    step(sw_x(5'd6), 32'h0); check_eq("x6", last_wd, 32'd11);
    step(sw_x(5'd7), 32'h0); check_eq("x7", last_wd, 32'd1);
    step(sw_x(5'd8), 32'h0); check_eq("x8", last_wd, 32'd1);
    step(sw_x(5'd3), 32'h0); check_eq("x3", last_wd, 32'd10);
    step(sw_x(5'd0), 32'h0); check_eq("x0", last_wd, 32'd0);

    step(enc_i(12'h200, 5'd0, 3'd0, 5'd5, 7'h13), 32'h0);
    step(enc_i(12'd2, 5'd5, 3'd0, 5'd11, 7'h03), 32'hFEF981F9); check_eq("lb_addr", last_alu, 32'h202);
    step(enc_i(12'd2, 5'd5, 3'd4, 5'd12, 7'h03), 32'hFEF981F9);
    step(enc_i(12'd2, 5'd5, 3'd1, 5'd13, 7'h03), 32'hFEF981F9);
    step(enc_i(12'd0, 5'd5, 3'd2, 5'd14, 7'h03), 32'hFEF981F9); check_eq("lw_addr", last_alu, 32'h200);
    step(sw_x(5'd11), 32'h0); check_eq("lb", last_wd, 32'hFFFFFFF9);
    step(sw_x(5'd12), 32'h0); check_eq("lbu", last_wd, 32'h000000F9);
    step(sw_x(5'd13), 32'h0); check_eq("lh", last_wd, 32'hFFFFFEF9);
    step(sw_x(5'd14), 32'h0); check_eq("lw", last_wd, 32'hFEF981F9);

    step(enc_u(20'h12345, 5'd5, 7'h37), 32'h0);
    step(enc_i(12'h688, 5'd5, 3'd0, 5'd5, 7'h13), 32'h0);
    step(enc_u(20'h00001, 5'd15, 7'h37), 32'h0);
    step(enc_s(12'h800, 5'd5, 5'd15, 3'd2), 32'h0);
    check_eq("sw_addr", last_alu, 32'h800);
    check_eq("sw_data", last_wd, 32'h12345688);
    check_eq("sw_size", {30'd0, last_mw}, 32'd3);
    step(enc_s(12'h800, 5'd5, 5'd15, 3'd1), 32'h0); check_eq("sh_size", {30'd0, last_mw}, 32'd2);
    step(enc_s(12'h800, 5'd5, 5'd15, 3'd0), 32'h0); check_eq("sb_size", {30'd0, last_mw}, 32'd1);
    step(enc_i(12'd0, 5'd0, 3'd0, 5'd0, 7'h13), 32'h0); check_eq("after_store_size", {30'd0, last_mw}, 32'd0);

    step(enc_i(12'hFFF, 5'd0, 3'd0, 5'd16, 7'h13), 32'h0);
    step(enc_i(12'd1, 5'd0, 3'd0, 5'd17, 7'h13), 32'h0);
    step(enc_i(12'h010, 5'd0, 3'd0, 5'd0, 7'h67), 32'h0);
    step(enc_b(13'd8, 5'd1, 5'd1, 3'd0), 32'h0);   check_eq("beq_at", last_pc, 32'h10);
    step(enc_b(13'd64, 5'd17, 5'd16, 3'd6), 32'h0); check_eq("beq_target", last_pc, 32'h18);
    step(32'h0, 32'h0);                            check_eq("bltu_not_taken", last_pc, 32'h1C);
    step(enc_j(21'd16, 5'd1), 32'h0);              check_eq("jal_at", last_pc, 32'h20);
    step(enc_i(12'd3, 5'd1, 3'd0, 5'd0, 7'h67), 32'h0); check_eq("jal_target", last_pc, 32'h30);
    step(enc_u(20'hFEF9F, 5'd9, 7'h37), 32'h0);    check_eq("jalr_target", last_pc, 32'h26);
    step(enc_i(12'h040, 5'd0, 3'd0, 5'd0, 7'h67), 32'h0);
    step(enc_u(20'h00001, 5'd10, 7'h17), 32'h0);   check_eq("auipc_at", last_pc, 32'h40);
    step(sw_x(5'd1), 32'h0);  check_eq("jal_link", last_wd, 32'h24);
    step(sw_x(5'd9), 32'h0);  check_eq("lui", last_wd, 32'hFEF9F000);
    step(sw_x(5'd10), 32'h0); check_eq("auipc", last_wd, 32'h1040);

    repeat (400) step(rand_instr(), $urandom);

    instr = sw_x(5'd1);
    rst_n = 1'b0;
    #2;
    check_eq("midrun_reset_pc", pc, 32'h0);
    check_eq("midrun_reset_memwrite", {30'd0, mem_write}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(enc_i(12'h7FF, 5'd0, 3'd0, 5'd0, 7'h13), 32'h0);
    check_eq("post_reset_pc", last_pc, 32'h0);
    for (int r = 1; r < 8; r++) begin
      step(sw_x(5'(r)), 32'h0);
      check_eq($sformatf("x%0d_cleared", r), last_wd, 32'h0);
    end

    repeat (100) step(rand_instr(), $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
